// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared RC4 types and constants for key-schedule and decrypt stages
package rc4_pkg;

  localparam int MSG_LEN_DEFAULT = 32;

  // Accepted plaintext alphabet: lowercase letters and space
  localparam logic [7:0] CHAR_LO    = 8'h61;
  localparam logic [7:0] CHAR_HI    = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [3:0] {
    IDLE,
    SET_I,
    WAIT_SI,
    LATCH_SI,
    WAIT_SJ,
    LATCH_SJ,
    WR_I,
    WR_J,
    WAIT_F,
    LATCH_F,
    WR_DEC,
    NEXT,
    DONE
  } state_t;

endpackage

// File: rtl/decrypt_message_if.sv
// rtl/decrypt_message_if.sv - control handshake and S/enc/dec memory ports of the decrypt stage
interface decrypt_message_if;
  logic       start;
  logic       finish;
  logic       fail;
  logic [7:0] s_address;
  logic [7:0] s_data;
  logic       s_wren;
  logic [7:0] s_q;
  logic [4:0] enc_address;
  logic [7:0] enc_q;
  logic [4:0] dec_address;
  logic [7:0] dec_data;
  logic       dec_wren;

  // master: the decrypt engine, which owns all memory address/write strobes
  modport master (
    input  start, s_q, enc_q,
    output finish, fail, s_address, s_data, s_wren, enc_address,
           dec_address, dec_data, dec_wren
  );

  // slave: the memories and the controller that issues start
  modport slave (
    output start, s_q, enc_q,
    input  finish, fail, s_address, s_data, s_wren, enc_address,
           dec_address, dec_data, dec_wren
  );
endinterface

// File: rtl/rc4_char_check.sv
// rtl/rc4_char_check.sv - combinational plaintext character validity test
module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] char_in,
  output logic       valid
);

  // A byte is plausible plaintext if it is a lowercase letter or a space
  assign valid = ((char_in >= CHAR_LO) && (char_in <= CHAR_HI)) || (char_in == CHAR_SPACE);

endmodule

// File: rtl/decrypt_message.sv
// rtl/decrypt_message.sv - RC4 PRGA decryption FSM; optional DECRYPT_VALID_CHECK_EN aborts on non-text bytes
module decrypt_message
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  decrypt_message_if.master  bus
);

  localparam logic [7:0] K_LAST = 8'(MSG_LEN - 1);

  state_t     state;
  logic [7:0] i, j, k;
  logic [7:0] si, sj, f, enc_byte;
  logic [7:0] s_address_r, s_data_r;
  logic [4:0] enc_address_r;
  logic       s_wren_r, dec_wren_r, finish_r;
  logic       stop_run;
  logic [7:0] dec_data;

  assign dec_data        = f ^ enc_byte;
  assign bus.s_address   = s_address_r;
  assign bus.s_data      = s_data_r;
  assign bus.s_wren      = s_wren_r;
  assign bus.enc_address = enc_address_r;
  assign bus.dec_address = k[4:0];
  assign bus.dec_data    = dec_data;
  assign bus.dec_wren    = dec_wren_r;
  assign bus.finish      = finish_r;

`ifdef DECRYPT_VALID_CHECK_EN
  logic char_valid, bad, fail_r;

  rc4_char_check u_char_check (
    .char_in (dec_data),
    .valid   (char_valid)
  );

  assign stop_run = (k == K_LAST) || bad;
  assign bus.fail = fail_r;
`else
  assign stop_run = (k == K_LAST);
  assign bus.fail = 1'b0;
`endif

  // Main sequencer: one PRGA byte per 11 states, every memory strobe registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      i             <= '0;
      j             <= '0;
      k             <= '0;
      si            <= '0;
      sj            <= '0;
      f             <= '0;
      enc_byte      <= '0;
      s_address_r   <= '0;
      s_data_r      <= '0;
      enc_address_r <= '0;
      s_wren_r      <= 1'b0;
      dec_wren_r    <= 1'b0;
      finish_r      <= 1'b0;
`ifdef DECRYPT_VALID_CHECK_EN
      bad           <= 1'b0;
      fail_r        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            i     <= '0;
            j     <= '0;
            k     <= '0;
            state <= SET_I;
          end
        end
        SET_I: begin
          i             <= i + 8'd1;
          s_address_r   <= i + 8'd1;
          enc_address_r <= k[4:0];
          state         <= WAIT_SI;
        end
        WAIT_SI: state <= LATCH_SI;
        LATCH_SI: begin
          si          <= bus.s_q;
          j           <= j + bus.s_q;
          s_address_r <= j + bus.s_q;
          state       <= WAIT_SJ;
        end
        WAIT_SJ: state <= LATCH_SJ;
        LATCH_SJ: begin
          // Set up the S[i] <= sj write so it is stable for all of WR_I
          sj          <= bus.s_q;
          s_address_r <= i;
          s_data_r    <= bus.s_q;
          s_wren_r    <= 1'b1;
          state       <= WR_I;
        end
        WR_I: begin
          // When i == j this rewrites the same location with si, which equals sj
          s_address_r <= j;
          s_data_r    <= si;
          state       <= WR_J;
        end
        WR_J: begin
          s_wren_r    <= 1'b0;
          s_address_r <= si + sj;
          state       <= WAIT_F;
        end
        WAIT_F: state <= LATCH_F;
        LATCH_F: begin
          f          <= bus.s_q;
          enc_byte   <= bus.enc_q;
          dec_wren_r <= 1'b1;
          state      <= WR_DEC;
        end
        WR_DEC: begin
          dec_wren_r <= 1'b0;
`ifdef DECRYPT_VALID_CHECK_EN
          bad        <= ~char_valid;
`endif
          state      <= NEXT;
        end
        NEXT: begin
          if (stop_run) begin
            finish_r <= 1'b1;
`ifdef DECRYPT_VALID_CHECK_EN
            fail_r   <= bad;
`endif
            state    <= DONE;
          end else begin
            k     <= k + 8'd1;
            state <= SET_I;
          end
        end
        DONE: begin
          finish_r <= 1'b0;
`ifdef DECRYPT_VALID_CHECK_EN
          fail_r   <= 1'b0;
          bad      <= 1'b0;
`endif
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/decrypt_message.md
DECRYPT_MESSAGE -- requirements
Module: decrypt_message

Interface
REQ-001 Parameter: MSG_LEN, default 32; the number of message bytes to decrypt (1..256).
REQ-002 Port: clk, input, 1, the only clock; all logic is on the rising edge.
REQ-003 Port: reset, input, 1, synchronous active-high reset.
REQ-004 Port: start, input, 1, one-cycle pulse that begins decryption; it is sampled only in IDLE.
REQ-005 Port: finish, output, 1, one-cycle pulse when the run ends (pass or fail).
REQ-006 Port: fail, output, 1, valid together with finish; 1 means the message was rejected.
REQ-007 Port: s_address / s_data / s_wren / s_q, out/out/out/in, 8/8/1/8, port to the shuffled S RAM.
REQ-008 Port: enc_address / enc_q, out/in, 5/8, port to the encrypted-message ROM.
REQ-009 Port: dec_address / dec_data / dec_wren, out/out/out, 5/8/1, port to the decrypted-message RAM.

Function
REQ-010 The block SHALL run RC4 PRGA with i=0, j=0, then for k = 0..MSG_LEN-1:
- i = i+1
- j = j+S[i]
- swap S[i] and S[j]
- f = S[S[i]+S[j]]
- dec[k] = f XOR enc[k]
REQ-011 All index and sum arithmetic SHALL be 8-bit modulo 256; k wraps only at MSG_LEN.
REQ-012 Memory reads SHALL take two cycles: the address is held for one wait cycle, and q is latched on the following cycle.
REQ-013 States SHALL be: IDLE, SET_I, WAIT_SI, LATCH_SI, WAIT_SJ, LATCH_SJ, WR_I, WR_J, WAIT_F, LATCH_F, WR_DEC, NEXT, DONE.
REQ-014 The per-byte state sequence SHALL be SET_I→...→NEXT, exactly 11 cycles per byte.
REQ-015 Per-state actions SHALL be:
- SET_I: i+1 is applied to s_address; k is applied to enc_address.
- LATCH_SI: si is captured; j takes j+si; s_address takes the new j.
- LATCH_SJ: sj is captured.
- WR_I: S[i] is written with sj.
- WR_J: S[j] is written with si.
- WAIT_F: s_address takes si+sj.
- LATCH_F: f is latched, and enc_q is also latched.
REQ-016 s_wren SHALL be 1 only in WR_I and WR_J, with address and data stable for the whole state.
REQ-017 dec_wren SHALL be 1 only in WR_DEC, with dec_address=k and dec_data=f XOR enc.
REQ-018 From NEXT, the FSM SHALL go to DONE if k==MSG_LEN-1; otherwise it increments k and returns to SET_I.
REQ-019 DONE SHALL last one cycle, pulse finish, and return to IDLE.
REQ-020 A run SHALL take MSG_LEN*11+1 cycles from the first cycle after start to finish.
REQ-021 A start pulse arriving while busy SHALL be ignored.
REQ-022 When i==j, the two writes SHALL both target the same address and leave S[i] unchanged (sj==si).

Reset
REQ-023 Reset SHALL force state=IDLE and set i, j, k, si, sj, f and all addresses/data to 0.
REQ-024 Reset SHALL set s_wren, dec_wren, finish and fail to 0.
REQ-025 Reset asserted mid-run SHALL abort within one cycle, with no further memory writes and no finish pulse.

Configuration
REQ-026 With DECRYPT_VALID_CHECK_EN defined, each decrypted byte SHALL be checked in WR_DEC; valid bytes are 0x61–0x7A or 0x20.
REQ-027 With DECRYPT_VALID_CHECK_EN defined, an invalid byte SHALL still be written, then the FSM goes straight to DONE with fail=1.
REQ-028 Without DECRYPT_VALID_CHECK_EN, fail SHALL be constant 0 and all MSG_LEN bytes are always processed.

Structure
REQ-029 The state enum, MSG_LEN default, and the valid-character bounds SHALL live in package rc4_pkg, shared with the key-schedule stage.
REQ-030 The character check SHALL be a combinational sub-module, rc4_char_check (in: 8-bit byte; out: valid).

Verification
REQ-031 Scenario 1: S RAM preloaded identity (S[n]=n), enc all 0x00, MSG_LEN=32, start.
- Response: dec[0]=0x02, and the S RAM after the run matches a software model.
- Response: finish occurs exactly 353 cycles after start.
REQ-032 Scenario 2: S loaded from key-schedule output for key 0x000000, enc = model-encrypted "abc..." text.
- Response: decrypted text matches byte-for-byte, with fail=0.
REQ-033 Scenario 3 (DECRYPT_VALID_CHECK_EN defined): enc chosen so that dec[3]=0x41.
- Response: finish with fail=1 after 4*11+1 cycles, and exactly 4 dec writes.
REQ-034 Scenario 4: reset asserted in cycle 20 of a run.
- Response: no writes on s_wren or dec_wren after that cycle, no finish pulse, and the FSM is in IDLE.
- Response: a following start completes normally.
REQ-035 Scenario 5: start re-pulsed in cycles 5 and 100 of a run.
- Response: ignored; a single finish pulse at cycle 353.
REQ-036 Scenario 6: S preloaded so that j==i at step 1.
- Response: S[1] is unchanged after the step, and f=S[2*S[1]] is used.
